// File: rtl/an_array_pkg.sv
// Shared types and constant-folding helpers for the AN-code array decoder:
// FSM encoding, the Barrett multiplier and the residue-to-error syndrome table.
package an_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_CORRECT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       neg;
    logic [5:0] idx;
  } synd_t;

  function automatic logic [63:0] barrett_m(input int unsigned cw_w, input int unsigned a);
    return (64'd1 << cw_w) / 64'(a);
  endfunction

  // Maps a nonzero residue to the single-bit arithmetic error +/-2^i that produces it.
  // Both passes run high-to-low so the smallest index wins; positive pass runs last so it wins ties.
  function automatic synd_t syndrome_lookup(input logic [31:0] r, input int unsigned a,
                                            input int unsigned cw_w);
    synd_t      s;
    logic [63:0] a64;
    logic [63:0] pm;
    s   = '0;
    a64 = 64'(a);
    for (int i = 31; i >= 0; i--) begin
      pm = (64'd1 << i) % a64;
      if (i < int'(cw_w) && ((a64 - pm) % a64) == {32'd0, r}) begin
        s.valid = 1'b1;
        s.neg   = 1'b1;
        s.idx   = 6'(i);
      end
    end
    for (int i = 31; i >= 0; i--) begin
      pm = (64'd1 << i) % a64;
      if (i < int'(cw_w) && pm == {32'd0, r}) begin
        s.valid = 1'b1;
        s.neg   = 1'b0;
        s.idx   = 6'(i);
      end
    end
    return s;
  endfunction

  // floor(2^idx / a): the message shift caused by a +2^idx error (negative errors use this + 1).
  function automatic logic [31:0] pow2_quot(input logic [5:0] idx, input int unsigned a);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (idx == 6'(i)) res = 32'((64'd1 << i) / 64'(a));
    end
    return res;
  endfunction

endpackage

// File: rtl/an_array_decoder_barrett_cell.sv
// Combinational per-cell AN-code check: q = cw / A and r = cw mod A via Barrett
// reduction with a single conditional correction, err = (r != 0).
module barrett_cell
  import an_array_pkg::*;
#(
  parameter int unsigned A    = 29,
  parameter int unsigned CW_W = 14,
  parameter int unsigned R_W  = 5
) (
  input  logic [CW_W-1:0] cw,
  output logic [CW_W-1:0] q,
  output logic [R_W-1:0]  r,
  output logic            err
);

  localparam logic [63:0]     M_FULL = barrett_m(CW_W, A);
  localparam logic [CW_W:0]   M_C    = M_FULL[CW_W:0];
  localparam logic [CW_W-1:0] A_C    = CW_W'(A);

  logic [2*CW_W-1:0] prod;
  logic [CW_W-1:0]   q_est;
  logic [CW_W-1:0]   qa;
  logic [CW_W-1:0]   rem;

  // The estimate undershoots the true quotient by at most one, so one subtract suffices.
  always_comb begin
    prod  = {{CW_W{1'b0}}, cw} * {{(CW_W-1){1'b0}}, M_C};
    q_est = prod[2*CW_W-1:CW_W];
    qa    = q_est * A_C;
    rem   = cw - qa;
    q     = q_est;
    r     = R_W'(rem);
    if (rem >= A_C) begin
      q = q_est + CW_W'(1);
      r = R_W'(rem - A_C);
    end
    err = (r != '0);
  end

endmodule

// File: rtl/an_array_decoder.sv
// AN-code array decoder: checks every cell of a ROWSxCOLS block in one cycle, then
// repairs up to MAX_CORR single-bit arithmetic errors, one flagged cell per cycle.
module an_array_decoder
  import an_array_pkg::*;
#(
  parameter int unsigned ROWS     = 5,
  parameter int unsigned COLS     = 5,
  parameter int unsigned A        = 29,
  parameter int unsigned CW_W     = 14,
  parameter int unsigned MSG_W    = 10,
  parameter int unsigned MAX_CORR = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ROWS*COLS*CW_W-1:0]           in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ROWS*COLS*MSG_W-1:0]          out_data,
  output logic [ROWS*COLS-1:0]                out_err_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]      out_corr_cnt,
  output logic                                out_uncorrectable
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and outputs hold until taken.

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned R_W   = $clog2(A + 1);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [32:0] MAX_MSG = 33'((64'd1 << MSG_W) - 64'd1);

  state_e               state_q, state_d;
  logic [N*CW_W-1:0]    cw_q, cw_d;
  logic [CW_W-1:0]      q_q [N];
  logic [CW_W-1:0]      q_d [N];
  logic [R_W-1:0]       r_q [N];
  logic [R_W-1:0]       r_d [N];
  logic [N-1:0]         err_map_q, err_map_d;
  logic [N-1:0]         pending_q, pending_d;
  logic [CNT_W-1:0]     corr_cnt_q, corr_cnt_d;
  logic                 uncorr_q, uncorr_d;

  logic [CW_W-1:0]      cell_q   [N];
  logic [R_W-1:0]       cell_r   [N];
  logic [N-1:0]         cell_err;

  logic [CNT_W-1:0]     flag_cnt;
  logic [IDX_W-1:0]     sel;
  synd_t                synd;
  logic [32:0]          delta;
  logic [32:0]          q_sel;
  logic [32:0]          fix_val;
  logic                 fix_ok;

  for (genvar k = 0; k < N; k++) begin : g_cell
    barrett_cell #(
      .A    (A),
      .CW_W (CW_W),
      .R_W  (R_W)
    ) u_cell (
      .cw  (cw_q[k*CW_W +: CW_W]),
      .q   (cell_q[k]),
      .r   (cell_r[k]),
      .err (cell_err[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    cw_d       = cw_q;
    q_d        = q_q;
    r_d        = r_q;
    err_map_d  = err_map_q;
    pending_d  = pending_q;
    corr_cnt_d = corr_cnt_q;
    uncorr_d   = uncorr_q;

    flag_cnt = '0;
    for (int k = 0; k < N; k++) flag_cnt = flag_cnt + CNT_W'(cell_err[k]);

    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pending_q[k]) sel = IDX_W'(k);
    end

    // The corrected message is q shifted by floor(2^i/A) (+1 for a negative error),
    // which avoids dividing (cw - e) by A in hardware.
    synd    = syndrome_lookup(32'(r_q[sel]), A, CW_W);
    delta   = {1'b0, pow2_quot(synd.idx, A)} + 33'(synd.neg);
    q_sel   = 33'(q_q[sel]);
    fix_val = synd.neg ? (q_sel + delta) : (q_sel - delta);
    fix_ok  = synd.valid && (synd.neg || (q_sel >= delta)) && (fix_val <= MAX_MSG);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cw_d       = in_data;
          err_map_d  = '0;
          pending_d  = '0;
          corr_cnt_d = '0;
          uncorr_d   = 1'b0;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        q_d       = cell_q;
        r_d       = cell_r;
        err_map_d = cell_err;
        if (flag_cnt > CNT_W'(MAX_CORR)) begin
          uncorr_d = 1'b1;
          state_d  = ST_DONE;
        end else if (flag_cnt == '0) begin
          state_d = ST_DONE;
        end else begin
          pending_d = cell_err;
          state_d   = ST_CORRECT;
        end
      end
      ST_CORRECT: begin
        pending_d[sel] = 1'b0;
        if (fix_ok) begin
          q_d[sel]   = fix_val[CW_W-1:0];
          corr_cnt_d = corr_cnt_q + CNT_W'(1);
        end else begin
          uncorr_d = 1'b1;
        end
        if (pending_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cw_q       <= '0;
      q_q        <= '{default: '0};
      r_q        <= '{default: '0};
      err_map_q  <= '0;
      pending_q  <= '0;
      corr_cnt_q <= '0;
      uncorr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cw_q       <= cw_d;
      q_q        <= q_d;
      r_q        <= r_d;
      err_map_q  <= err_map_d;
      pending_q  <= pending_d;
      corr_cnt_q <= corr_cnt_d;
      uncorr_q   <= uncorr_d;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) out_data[k*MSG_W +: MSG_W] = MSG_W'(q_q[k]);
  end

  assign in_ready          = (state_q == ST_IDLE);
  assign out_valid         = (state_q == ST_DONE);
  assign out_err_map       = err_map_q;
  assign out_corr_cnt      = corr_cnt_q;
  assign out_uncorrectable = uncorr_q;

endmodule

// File: doc/an_array_decoder.md
AN_ARRAY_DECODER -- requirements
Module: an_array_decoder

Interface
REQ-001 SHALL have parameter ROWS, default 5: rows of the codeword array.
REQ-002 SHALL have parameter COLS, default 5: columns of the codeword array.
REQ-003 SHALL have parameter A, default 29: odd AN-code constant.
REQ-004 SHALL have parameter CW_W, default 14, and MSG_W, default 10: codeword and message widths.
REQ-005 SHALL have parameter MAX_CORR, default 2: maximum corrected cells per block (1..ROWS*COLS).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port in_valid, input, 1: input block valid.
REQ-009 SHALL have port in_ready, output, 1: block accepted when in_valid && in_ready.
REQ-010 SHALL have port in_data, input, ROWS*COLS*CW_W: codewords, cell k=r*COLS+c at bits [k*CW_W +: CW_W].
REQ-011 SHALL have port out_valid, input-side pair out_ready, input, 1: output handshake.
REQ-012 SHALL have port out_valid, output, 1, and out_data, output, ROWS*COLS*MSG_W: decoded messages, same cell packing.
REQ-013 SHALL have port out_err_map, output, ROWS*COLS: per-cell nonzero-residue flags.
REQ-014 SHALL have port out_corr_cnt, output, $clog2(ROWS*COLS+1): cells corrected.
REQ-015 SHALL have port out_uncorrectable, output, 1: block exceeded correction capability.

Function
REQ-016 SHALL implement FSM IDLE, CHECK, CORRECT, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE: on handshake, register in_data, go to CHECK.
REQ-018 CHECK (one cycle): per cell register q=floor(cw/A), r=cw mod A via Barrett (m=floor(2^CW_W/A), one conditional subtract), err=(r!=0); exact for all cw < 2^CW_W.
REQ-019 CHECK: if popcount(err) > MAX_CORR, set uncorrectable, go to DONE with all outputs = q; else if no err go to DONE; else go to CORRECT.
REQ-020 CORRECT: one flagged cell per cycle, lowest index first; find e=+/-2^i, i<CW_W, with e mod A = r; message=(cw-e)/A; overwrite that cell's q, clear its pending bit, increment corr_cnt.
REQ-021 If no e matches, or (cw-e) is negative or /A exceeds 2^MSG_W-1, cell keeps q, uncorrectable set, scan continues.
REQ-022 Tie for +2^i and -2^j on same r: choose positive, smallest i.
REQ-023 CORRECT exits to DONE the cycle after the last pending cell; latency handshake->out_valid = 2 + number of flagged cells (<= MAX_CORR).
REQ-024 DONE: out_valid=1, outputs stable until out_valid && out_ready, then IDLE; in_ready rises the next cycle (no same-cycle accept).
REQ-025 out_err_map reflects CHECK-time flags, not post-correction state.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, out_data=0, out_err_map=0, out_corr_cnt=0, out_uncorrectable=0.
REQ-027 Reset in any state SHALL discard the in-flight block with no partial output.

Structure
REQ-028 Package an_array_pkg SHALL hold state enum, Barrett constant function, and error-syndrome lookup function (r -> sign, i, valid).
REQ-029 One sub-module barrett_cell (cw in; q, r, err out, combinational) SHALL be instantiated ROWS*COLS times via generate; one shared syndrome lookup serves CORRECT.

Verification (defaults A=29)
REQ-030 All cells 2900 (msg 100) -> out_valid 2 cycles after accept, all out_data=100, err_map=0, corr_cnt=0.
REQ-031 Cell 12 = 2908 (+2^3), rest clean -> r=8, cell 12 = 100, err_map bit 12 only, corr_cnt=1, latency 3.
REQ-032 Cells 0 = 2899 (-2^0), 24 = 2932 (+2^5) -> both 100, corr_cnt=2, latency 4, cell 0 corrected first.
REQ-033 Three flagged cells -> uncorrectable=1, corr_cnt=0, outputs raw q (2908 -> 100, 2899 -> 99), latency 2.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; rst_n=0 during CORRECT -> next cycle IDLE, out_valid=0.
